// File: rtl/calc_input_ctrl.sv
// Button/switch front end for the stack calculator: synchronise, debounce, turn
// presses into single-cycle commands, and hold the operand between commands.
module calc_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLDOFF_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_push,
  input  logic       btn_shift,
  input  logic       btn_op,
  input  logic       btn_reset,
  input  logic [7:0] sw_number,
  input  logic [2:0] sw_op,
  output logic       push_num,
  output logic       shift_and_push,
  output logic       do_other_op,
  output logic       calc_reset,
  output logic [7:0] input_number,
  output logic [2:0] other_op_code,
  output logic       busy,
  output logic       dropped
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLDOFF} state_t;

  // Button bit order everywhere: 0 push, 1 shift, 2 op, 3 reset.
  logic [3:0]    btn_raw;
  logic [3:0]    btn_s1, btn_s2;
  logic [7:0]    num_s1, num_s2;
  logic [2:0]    op_s1, op_s2;
  logic [DW-1:0] db_cnt [4];
  logic [3:0]    stable, stable_prev, press_q;

  state_t        state, state_d;
  logic [2:0]    cmd, cmd_d;
  logic [HW-1:0] hold_cnt, hold_d;
  logic          capture, drop_d, creset_d, calc_reset_q;
  logic [2:0]    cmd_press, cmd_win;
  logic          cmd_multi;

  assign btn_raw = {btn_reset, btn_op, btn_shift, btn_push};

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      num_s1 <= '0;
      num_s2 <= '0;
      op_s1  <= '0;
      op_s2  <= '0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
      num_s1 <= sw_number;
      num_s2 <= num_s1;
      op_s1  <= sw_op;
      op_s2  <= op_s1;
    end
  end

  // Stable state flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      stable      <= '0;
      stable_prev <= '0;
      press_q     <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (btn_s2[i] != stable[i]) begin
          if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
            stable[i] <= ~stable[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
      stable_prev <= stable;
      press_q     <= stable & ~stable_prev;
    end
  end

  // Commands have no back-pressure: a press is either issued as a one-cycle
  // pulse while IDLE or refused (dropped pulses); nothing is ever queued.
  assign cmd_press = press_q[2:0];
  assign cmd_win   = cmd_press & (~cmd_press + 3'd1);
  assign cmd_multi = (cmd_press & (cmd_press - 3'd1)) != 3'd0;

  always_comb begin
    state_d  = state;
    cmd_d    = cmd;
    hold_d   = hold_cnt;
    capture  = 1'b0;
    drop_d   = 1'b0;
    creset_d = 1'b0;
    if (press_q[3]) begin
      state_d  = IDLE;
      hold_d   = '0;
      creset_d = 1'b1;
      drop_d   = |cmd_press;
    end else begin
      case (state)
        IDLE: begin
          if (|cmd_press) begin
            state_d = ISSUE;
            cmd_d   = cmd_win;
            capture = 1'b1;
            drop_d  = cmd_multi;
          end
        end
        ISSUE: begin
          state_d = HOLDOFF;
          hold_d  = '0;
          drop_d  = |cmd_press;
        end
        HOLDOFF: begin
          drop_d = |cmd_press;
          if (hold_cnt == HW'(HOLDOFF_CYCLES - 1)) begin
            state_d = IDLE;
          end else begin
            hold_d = hold_cnt + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cmd           <= '0;
      hold_cnt      <= '0;
      busy          <= 1'b0;
      dropped       <= 1'b0;
      calc_reset_q  <= 1'b0;
      input_number  <= '0;
      other_op_code <= '0;
    end else begin
      state        <= state_d;
      cmd          <= cmd_d;
      hold_cnt     <= hold_d;
      busy         <= (state_d != IDLE);
      dropped      <= drop_d;
      calc_reset_q <= creset_d;
      if (capture) begin
        input_number  <= num_s2;
        other_op_code <= op_s2;
      end
    end
  end

  assign push_num       = (state == ISSUE) && cmd[0];
  assign shift_and_push = (state == ISSUE) && cmd[1];
  assign do_other_op    = (state == ISSUE) && cmd[2];
  assign calc_reset     = reset | calc_reset_q;

endmodule

// File: tb/tb_calc_input_ctrl.sv
// Bench for calc_input_ctrl: directed scenarios plus random button/switch
// activity, checked each cycle against a timeline model of accept/refuse rules.
module tb_calc_input_ctrl;

  localparam int D = 4;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_push = 1'b0, btn_shift = 1'b0, btn_op = 1'b0, btn_reset = 1'b0;
  logic [7:0] sw_number = '0;
  logic [2:0] sw_op = '0;
  logic       push_num, shift_and_push, do_other_op, calc_reset, busy, dropped;
  logic [7:0] input_number;
  logic [2:0] other_op_code;

  calc_input_ctrl #(.DEBOUNCE_CYCLES(D), .HOLDOFF_CYCLES(H)) dut (
    .clk(clk), .reset(reset),
    .btn_push(btn_push), .btn_shift(btn_shift), .btn_op(btn_op), .btn_reset(btn_reset),
    .sw_number(sw_number), .sw_op(sw_op),
    .push_num(push_num), .shift_and_push(shift_and_push), .do_other_op(do_other_op),
    .calc_reset(calc_reset), .input_number(input_number), .other_op_code(other_op_code),
    .busy(busy), .dropped(dropped)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Synchroniser = 2-sample delay; a button is "pressed" when it has looked
  // different from its settled level for D samples; a press is decided two
  // cycles later, accepted only when the previous command's busy window
  // (pulse cycle + H hold-off cycles) ended at least one cycle earlier.
  logic [3:0] m_s1, m_s2, m_stable, m_p1, m_p2, m_dec, m_nst;
  logic [7:0] m_n1, m_n2;
  logic [2:0] m_o1, m_o2;
  int         m_run [4];
  int         busy_last;
  logic       e_push, e_shift, e_op, e_creset, e_busy, e_drop;
  logic [7:0] e_num;
  logic [2:0] e_opc;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_p1 = '0; m_p2 = '0;
        m_n1 = '0; m_n2 = '0; m_o1 = '0; m_o2 = '0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        busy_last = cyc - 1;
        e_push = 0; e_shift = 0; e_op = 0; e_creset = 1; e_busy = 0; e_drop = 0;
        e_num = '0; e_opc = '0;
      end else begin
        m_dec = m_p2;
        e_push = 0; e_shift = 0; e_op = 0; e_creset = 0; e_drop = 0;
        if (m_dec[3]) begin
          e_creset  = 1;
          e_drop    = |m_dec[2:0];
          busy_last = cyc - 1;
        end else if (m_dec[2:0] != 3'd0) begin
          if (cyc >= busy_last + 2) begin
            if (m_dec[0])      e_push = 1;
            else if (m_dec[1]) e_shift = 1;
            else               e_op = 1;
            e_num     = m_n2;
            e_opc     = m_o2;
            busy_last = cyc + H;
            e_drop    = ($countones(m_dec[2:0]) > 1);
          end else begin
            e_drop = 1;
          end
        end
        e_busy = (cyc <= busy_last);
        m_nst = m_stable;
        for (int i = 0; i < 4; i++) begin
          if (m_s2[i] != m_stable[i]) begin
            if (m_run[i] == D - 1) begin
              m_nst[i] = ~m_stable[i];
              m_run[i] = 0;
            end else begin
              m_run[i]++;
            end
          end else begin
            m_run[i] = 0;
          end
        end
        m_p2 = m_p1;
        m_p1 = m_nst & ~m_stable;
        m_stable = m_nst;
        m_s2 = m_s1;
        m_s1 = {btn_reset, btn_op, btn_shift, btn_push};
        m_n2 = m_n1; m_n1 = sw_number;
        m_o2 = m_o1; m_o1 = sw_op;
      end
    end
  end

  // ---------------- compare + event monitor ----------------
  int n_push = 0, n_shift = 0, n_op = 0, n_creset = 0, n_drop = 0, n_busy = 0;
  int last_push_cyc = -1, last_op_cyc = -1, last_creset_cyc = -1;
  logic drop_at_push = 0, busy_after_creset = 1, prev_creset = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        chk("push_num", push_num, e_push);
        chk("shift_and_push", shift_and_push, e_shift);
        chk("do_other_op", do_other_op, e_op);
        chk("calc_reset", calc_reset, e_creset);
        chk("busy", busy, e_busy);
        chk("dropped", dropped, e_drop);
        chk("input_number", input_number, e_num);
        chk("other_op_code", other_op_code, e_opc);
        if ((32'(push_num) + 32'(shift_and_push) + 32'(do_other_op) + 32'(calc_reset)) > 1)
          chk("one_hot_cmds", 0, 1);
      end
      if (!reset) begin
        if (prev_creset) busy_after_creset = busy;
        prev_creset = calc_reset;
        if (push_num) begin n_push++; last_push_cyc = cyc; drop_at_push = dropped; end
        if (shift_and_push) n_shift++;
        if (do_other_op) begin n_op++; last_op_cyc = cyc; end
        if (calc_reset) begin n_creset++; last_creset_cyc = cyc; end
        if (dropped) n_drop++;
        if (busy) n_busy++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  int b_push, b_shift, b_op, b_creset, b_drop, b_busy, t0;

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic base();
    b_push = n_push; b_shift = n_shift; b_op = n_op;
    b_creset = n_creset; b_drop = n_drop; b_busy = n_busy;
  endtask

  // Call right after changing inputs: t0 = first edge that samples them.
  task automatic arm();
    @(negedge clk);
    t0 = cyc;
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    step(4);
    chk("rst_calc_reset", calc_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_input_number", input_number, 0);
    chk("rst_push_num", push_num, 0);
    reset = 1'b0;
    step(3);

    // Basic push latency, capture and busy window.
    base();
    sw_number = 8'h2A;
    btn_push = 1'b1;
    arm();
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      #1;
      if (cyc - t0 == 15) chk("t1_busy_c15", busy, 1);
      if (cyc - t0 == 16) chk("t1_busy_c16", busy, 0);
      if (cyc - t0 == 7)  chk("t1_num_c7", input_number, 8'h2A);
    end
    chk("t1_push_cycle", last_push_cyc - t0, 7);
    chk("t1_push_count", n_push - b_push, 1);
    chk("t1_busy_cycles", n_busy - b_busy, 9);
    btn_push = 1'b0;
    step(15);

    // Short bounce never registers.
    base();
    btn_push = 1'b1; step(1);
    btn_push = 1'b0; step(1);
    btn_push = 1'b1; step(1);
    btn_push = 1'b0; step(20);
    chk("t2_push_count", n_push - b_push, 0);
    chk("t2_drop_count", n_drop - b_drop, 0);
    chk("t2_busy_cycles", n_busy - b_busy, 0);

    // Opcode held while switches move.
    base();
    sw_op = 3'b111;
    btn_op = 1'b1;
    arm();
    step(6);
    btn_op = 1'b0;
    step(3);
    sw_op = 3'b000;
    for (int k = 0; k < 20; k++) begin
      step(1);
      chk("t3_opcode_held", other_op_code, 3'b111);
    end
    chk("t3_op_cycle", last_op_cyc - t0, 7);
    chk("t3_op_count", n_op - b_op, 1);

    // Shift press landing in hold-off is dropped, later one is accepted.
    base();
    sw_number = 8'h11;
    btn_push = 1'b1;
    arm();
    step(3); btn_shift = 1'b1;
    step(3); btn_push = 1'b0;
    step(3); btn_shift = 1'b0;
    step(25);
    chk("t4_push_count", n_push - b_push, 1);
    chk("t4_shift_dropped", n_shift - b_shift, 0);
    chk("t4_drop_count", n_drop - b_drop, 1);
    base();
    btn_shift = 1'b1; step(6);
    btn_shift = 1'b0; step(25);
    chk("t4_shift_count", n_shift - b_shift, 1);
    chk("t4_drop_none", n_drop - b_drop, 0);

    // Simultaneous push and op: push wins, op dropped in the same cycle.
    base();
    btn_push = 1'b1; btn_op = 1'b1;
    arm();
    step(6);
    btn_push = 1'b0; btn_op = 1'b0;
    step(25);
    chk("t5_push_count", n_push - b_push, 1);
    chk("t5_op_count", n_op - b_op, 0);
    chk("t5_drop_count", n_drop - b_drop, 1);
    chk("t5_drop_with_push", drop_at_push, 1);

    // Calculator reset during hold-off.
    base();
    sw_number = 8'h55;
    btn_push = 1'b1;
    arm();
    step(4); btn_reset = 1'b1;
    step(2); btn_push = 1'b0;
    step(4); btn_reset = 1'b0; sw_number = 8'h99;
    step(25);
    chk("t6_creset_count", n_creset - b_creset, 1);
    chk("t6_creset_cycle", last_creset_cyc - t0, 12);
    chk("t6_busy_after", busy_after_creset, 0);
    chk("t6_num_kept", input_number, 8'h55);
    base();
    btn_push = 1'b1; step(6);
    btn_push = 1'b0; step(25);
    chk("t6_push_after", n_push - b_push, 1);
    chk("t6_num_new", input_number, 8'h99);

    // Random buttons and switches, model-checked every cycle.
    for (int seg = 0; seg < 300; seg++) begin
      int len;
      len = $urandom_range(1, 10);
      btn_push  = ($urandom_range(0, 2) == 0);
      btn_shift = ($urandom_range(0, 2) == 0);
      btn_op    = ($urandom_range(0, 2) == 0);
      btn_reset = ($urandom_range(0, 15) == 0);
      repeat (len) begin
        sw_number = 8'($urandom);
        sw_op     = 3'($urandom);
        step(1);
      end
    end
    btn_push = 1'b0; btn_shift = 1'b0; btn_op = 1'b0; btn_reset = 1'b0;
    step(30);

    // Button held through module reset.
    btn_op = 1'b1;
    reset = 1'b1;
    step(3);
    chk("t7_rst_calc_reset", calc_reset, 1);
    base();
    reset = 1'b0;
    arm();
    step(12);
    btn_op = 1'b0;
    step(20);
    chk("t7_op_cycle", last_op_cyc - t0, 7);
    chk("t7_op_count", n_op - b_op, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
